// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. It owns the PC
// enable and the enable/clear strobes of the IF/ID, ID/EX, EX/MEM and MEM/WB
// latches. It sequences four conditions: load-use bubbles, taken-branch
// squashes, memory wait states, and the halt drain.
//
// Optional build macro: HAZARD_PERF_EN
//   When defined, adds free-running performance counters (stall_cycles,
//   flush_count, ldu_count). When undefined, those ports and that logic are
//   absent, and the sequencing behaviour is unchanged.

module pipeline_hazard_ctrl #(
    parameter int REG_W      = 5,
    parameter int LU_BUBBLES = 1,
    parameter int DWAIT_MAX  = 255,
    parameter int CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_memRd,
    input  logic             mem_dren,
    input  logic             mem_dwen,
    input  logic             dhit,
    input  logic             ihit,
    input  logic             mem_branch_taken,
    input  logic             wb_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             halted,
`ifdef HAZARD_PERF_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic [CNT_W-1:0] ldu_count,
`endif
    output logic             mem_timeout
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LDUSE  = 2'd1,
        DWAIT  = 2'd2,
        HALTED = 2'd3
    } state_e;

    // Bubble count still owed after the first bubble of a load-use hazard.
    localparam logic [1:0] LuLoad = 2'(LU_BUBBLES - 1);

    state_e     state_q, state_d;
    logic [1:0] bub_cnt_q, bub_cnt_d;
    logic [7:0] dwait_cnt_q, dwait_cnt_d;
    logic       mem_timeout_q, mem_timeout_d;

    logic       loadUse;
    logic       dataWait;

    logic       pcEnRaw;
    logic       ifidEnRaw;
    logic       idexEnRaw;
    logic       exmemEnRaw;
    logic       memwbEnRaw;
    logic       ifidFlushRaw;
    logic       idexFlushRaw;
    logic       exmemFlushRaw;

    logic       branchEvt;
    logic       lduEvt;

    // Hazard conditions decoded straight from the stage latches; register 0
    // is hardwired to zero and can never carry a real dependency.
    assign loadUse  = ex_memRd && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign dataWait = (mem_dren || mem_dwen) && !dhit;

    // Priority resolution of stall/flush strobes and the next sequencer state.
    always_comb begin
        state_d       = state_q;
        bub_cnt_d     = bub_cnt_q;
        dwait_cnt_d   = dwait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        pcEnRaw       = 1'b0;
        ifidEnRaw     = 1'b0;
        idexEnRaw     = 1'b0;
        exmemEnRaw    = 1'b0;
        memwbEnRaw    = 1'b0;
        ifidFlushRaw  = 1'b0;
        idexFlushRaw  = 1'b0;
        exmemFlushRaw = 1'b0;
        branchEvt     = 1'b0;
        lduEvt        = 1'b0;

        if (state_q == HALTED) begin
            state_d = HALTED;
        end else if (wb_halt) begin
            state_d = HALTED;
        end else if (dataWait) begin
            state_d     = DWAIT;
            dwait_cnt_d = (dwait_cnt_q == 8'hFF) ? dwait_cnt_q : dwait_cnt_q + 8'd1;
            if (int'(dwait_cnt_d) >= DWAIT_MAX) begin
                mem_timeout_d = 1'b1;
            end
        end else if (state_q == DWAIT) begin
            pcEnRaw     = 1'b1;
            ifidEnRaw   = 1'b1;
            idexEnRaw   = 1'b1;
            exmemEnRaw  = 1'b1;
            memwbEnRaw  = 1'b1;
            dwait_cnt_d = 8'd0;
            state_d     = (bub_cnt_q != 2'd0) ? LDUSE : RUN;
        end else if (mem_branch_taken) begin
            pcEnRaw       = 1'b1;
            ifidEnRaw     = 1'b1;
            idexEnRaw     = 1'b1;
            exmemEnRaw    = 1'b1;
            memwbEnRaw    = 1'b1;
            ifidFlushRaw  = 1'b1;
            idexFlushRaw  = 1'b1;
            exmemFlushRaw = 1'b1;
            bub_cnt_d     = 2'd0;
            state_d       = RUN;
            branchEvt     = 1'b1;
        end else if ((state_q == LDUSE) && (bub_cnt_q != 2'd0)) begin
            idexEnRaw    = 1'b1;
            idexFlushRaw = 1'b1;
            exmemEnRaw   = 1'b1;
            memwbEnRaw   = 1'b1;
            bub_cnt_d    = bub_cnt_q - 2'd1;
            state_d      = (bub_cnt_q == 2'd1) ? RUN : LDUSE;
        end else if (loadUse) begin
            idexEnRaw    = 1'b1;
            idexFlushRaw = 1'b1;
            exmemEnRaw   = 1'b1;
            memwbEnRaw   = 1'b1;
            bub_cnt_d    = LuLoad;
            state_d      = (LuLoad != 2'd0) ? LDUSE : RUN;
            lduEvt       = 1'b1;
        end else if (!ihit) begin
            idexEnRaw    = 1'b1;
            idexFlushRaw = 1'b1;
            exmemEnRaw   = 1'b1;
            memwbEnRaw   = 1'b1;
            state_d      = RUN;
        end else begin
            pcEnRaw    = 1'b1;
            ifidEnRaw  = 1'b1;
            idexEnRaw  = 1'b1;
            exmemEnRaw = 1'b1;
            memwbEnRaw = 1'b1;
            state_d    = RUN;
        end
    end

    // Sequencer state, bubble/wait counters and the sticky timeout flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= RUN;
            bub_cnt_q     <= 2'd0;
            dwait_cnt_q   <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bub_cnt_q     <= bub_cnt_d;
            dwait_cnt_q   <= dwait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // All latch strobes are held off while reset is asserted.
    assign pc_en       = pcEnRaw       && !RST;
    assign ifid_en     = ifidEnRaw     && !RST;
    assign idex_en     = idexEnRaw     && !RST;
    assign exmem_en    = exmemEnRaw    && !RST;
    assign memwb_en    = memwbEnRaw    && !RST;
    assign ifid_flush  = ifidFlushRaw  && !RST;
    assign idex_flush  = idexFlushRaw  && !RST;
    assign exmem_flush = exmemFlushRaw && !RST;
    assign halted      = (state_q == HALTED);
    assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] flush_count_q;
    logic [CNT_W-1:0] ldu_count_q;

    // Performance counters; they wrap naturally and freeze once halted.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
            ldu_count_q    <= '0;
        end else if (state_q != HALTED) begin
            if (!pcEnRaw) begin
                stall_cycles_q <= stall_cycles_q + CNT_W'(1);
            end
            if (branchEvt) begin
                flush_count_q <= flush_count_q + CNT_W'(1);
            end
            if (lduEvt) begin
                ldu_count_q <= ldu_count_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
    assign ldu_count    = ldu_count_q;
`else
    // Without the counters the event strobes have no consumer.
    logic perf_unused;
    assign perf_unused = branchEvt ^ lduEvt ^ (CNT_W > 0);
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl. Two instances share one stimulus
// stream: dutA uses a single load-use bubble, dutB uses two. Both use a
// data-wait timeout threshold of 3. Build with HAZARD_PERF_EN to also check
// the performance counters.

module tb_pipeline_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [4:0] idRs, idRt, exRt;
    logic       exMemRd, memDren, memDwen, dhit, ihit, branchTaken, wbHalt;

    logic aPcEn, aIfidEn, aIdexEn, aExmemEn, aMemwbEn;
    logic aIfidFl, aIdexFl, aExmemFl, aHalted, aTimeout;
    logic bPcEn, bIfidEn, bIdexEn, bExmemEn, bMemwbEn;
    logic bIfidFl, bIdexFl, bExmemFl, bHalted, bTimeout;
`ifdef HAZARD_PERF_EN
    logic [31:0] aStall, aFlushCnt, aLduCnt;
    logic [31:0] bStall, bFlushCnt, bLduCnt;
`endif

    logic [4:0] aEn, bEn;
    logic [2:0] aFl, bFl;
    assign aEn = {aPcEn, aIfidEn, aIdexEn, aExmemEn, aMemwbEn};
    assign aFl = {aIfidFl, aIdexFl, aExmemFl};
    assign bEn = {bPcEn, bIfidEn, bIdexEn, bExmemEn, bMemwbEn};
    assign bFl = {bIfidFl, bIdexFl, bExmemFl};

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(.REG_W(5), .LU_BUBBLES(1), .DWAIT_MAX(3), .CNT_W(32)) dutA (
        .CLK(CLK), .RST(RST),
        .id_rs(idRs), .id_rt(idRt), .ex_rt(exRt), .ex_memRd(exMemRd),
        .mem_dren(memDren), .mem_dwen(memDwen), .dhit(dhit), .ihit(ihit),
        .mem_branch_taken(branchTaken), .wb_halt(wbHalt),
        .pc_en(aPcEn), .ifid_en(aIfidEn), .idex_en(aIdexEn),
        .exmem_en(aExmemEn), .memwb_en(aMemwbEn),
        .ifid_flush(aIfidFl), .idex_flush(aIdexFl), .exmem_flush(aExmemFl),
        .halted(aHalted),
`ifdef HAZARD_PERF_EN
        .stall_cycles(aStall), .flush_count(aFlushCnt), .ldu_count(aLduCnt),
`endif
        .mem_timeout(aTimeout)
    );

    pipeline_hazard_ctrl #(.REG_W(5), .LU_BUBBLES(2), .DWAIT_MAX(3), .CNT_W(32)) dutB (
        .CLK(CLK), .RST(RST),
        .id_rs(idRs), .id_rt(idRt), .ex_rt(exRt), .ex_memRd(exMemRd),
        .mem_dren(memDren), .mem_dwen(memDwen), .dhit(dhit), .ihit(ihit),
        .mem_branch_taken(branchTaken), .wb_halt(wbHalt),
        .pc_en(bPcEn), .ifid_en(bIfidEn), .idex_en(bIdexEn),
        .exmem_en(bExmemEn), .memwb_en(bMemwbEn),
        .ifid_flush(bIfidFl), .idex_flush(bIdexFl), .exmem_flush(bExmemFl),
        .halted(bHalted),
`ifdef HAZARD_PERF_EN
        .stall_cycles(bStall), .flush_count(bFlushCnt), .ldu_count(bLduCnt),
`endif
        .mem_timeout(bTimeout)
    );

    // Return every input to a quiet, instruction-fetch-hitting pipeline.
    task automatic applyStimulus();
        idRs        = 5'd0;
        idRt        = 5'd0;
        exRt        = 5'd0;
        exMemRd     = 1'b0;
        memDren     = 1'b0;
        memDwen     = 1'b0;
        dhit        = 1'b0;
        ihit        = 1'b1;
        branchTaken = 1'b0;
        wbHalt      = 1'b0;
    endtask

    // Move to the next cycle: inputs change on the falling edge.
    task automatic nextCycle();
        @(negedge CLK);
        applyStimulus();
    endtask

    // Sample point, well clear of the rising edge.
    task automatic settle();
        #2;
    endtask

    task automatic pulseReset();
        @(negedge CLK);
        applyStimulus();
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        settle();
        if (aEn !== 5'b00000) begin bad++; $display("FAIL reset_en_1: got %b want %b", aEn, 5'b00000); end
        total++;
        if (aFl !== 3'b000) begin bad++; $display("FAIL reset_flush_1: got %b want %b", aFl, 3'b000); end
        total++;
        @(negedge CLK);
        settle();
        if (aEn !== 5'b00000) begin bad++; $display("FAIL reset_en_2: got %b want %b", aEn, 5'b00000); end
        total++;
        @(negedge CLK);
        RST = 1'b0;
        settle();
        if (aEn !== 5'b11111) begin bad++; $display("FAIL post_reset_en: got %b want %b", aEn, 5'b11111); end
        total++;
        if (aFl !== 3'b000) begin bad++; $display("FAIL post_reset_flush: got %b want %b", aFl, 3'b000); end
        total++;
        if (aHalted !== 1'b0) begin bad++; $display("FAIL post_reset_halted: got %b want %b", aHalted, 1'b0); end
        total++;
        if (aTimeout !== 1'b0) begin bad++; $display("FAIL post_reset_timeout: got %b want %b", aTimeout, 1'b0); end
        total++;
    endtask

    task automatic test_load_use();
        // rs match
        nextCycle();
        exMemRd = 1'b1; exRt = 5'd5; idRs = 5'd5; idRt = 5'd9;
        settle();
        if (aEn !== 5'b00111) begin bad++; $display("FAIL lu_rs_en: got %b want %b", aEn, 5'b00111); end
        total++;
        if (aFl !== 3'b010) begin bad++; $display("FAIL lu_rs_flush: got %b want %b", aFl, 3'b010); end
        total++;
        nextCycle();
        settle();
        if (aEn !== 5'b11111) begin bad++; $display("FAIL lu_after_en: got %b want %b", aEn, 5'b11111); end
        total++;
        if (aFl !== 3'b000) begin bad++; $display("FAIL lu_after_flush: got %b want %b", aFl, 3'b000); end
        total++;
        // rt match
        nextCycle();
        exMemRd = 1'b1; exRt = 5'd7; idRs = 5'd3; idRt = 5'd7;
        settle();
        if (aEn !== 5'b00111) begin bad++; $display("FAIL lu_rt_en: got %b want %b", aEn, 5'b00111); end
        total++;
        nextCycle();
        // register zero never stalls
        nextCycle();
        exMemRd = 1'b1; exRt = 5'd0; idRs = 5'd0; idRt = 5'd0;
        settle();
        if (aEn !== 5'b11111) begin bad++; $display("FAIL lu_r0_en: got %b want %b", aEn, 5'b11111); end
        total++;
        if (bEn !== 5'b11111) begin bad++; $display("FAIL lu_r0_en_b: got %b want %b", bEn, 5'b11111); end
        total++;
        // matching registers but not a load
        nextCycle();
        exMemRd = 1'b0; exRt = 5'd5; idRs = 5'd5;
        settle();
        if (aEn !== 5'b11111) begin bad++; $display("FAIL lu_noload_en: got %b want %b", aEn, 5'b11111); end
        total++;
    endtask

    task automatic test_load_use_two();
        nextCycle();
        exMemRd = 1'b1; exRt = 5'd4; idRs = 5'd4;
        settle();
        if (bEn !== 5'b00111) begin bad++; $display("FAIL lu2_bub1_en: got %b want %b", bEn, 5'b00111); end
        total++;
        nextCycle();
        settle();
        if (bEn !== 5'b00111) begin bad++; $display("FAIL lu2_bub2_en: got %b want %b", bEn, 5'b00111); end
        total++;
        if (bFl !== 3'b010) begin bad++; $display("FAIL lu2_bub2_flush: got %b want %b", bFl, 3'b010); end
        total++;
        if (aEn !== 5'b11111) begin bad++; $display("FAIL lu1_no_second_en: got %b want %b", aEn, 5'b11111); end
        total++;
        nextCycle();
        settle();
        if (bEn !== 5'b11111) begin bad++; $display("FAIL lu2_done_en: got %b want %b", bEn, 5'b11111); end
        total++;
        // pending second bubble survives a data wait
        nextCycle();
        exMemRd = 1'b1; exRt = 5'd6; idRt = 5'd6;
        nextCycle();
        memDren = 1'b1;
        settle();
        if (bEn !== 5'b00000) begin bad++; $display("FAIL lu2_wait_en: got %b want %b", bEn, 5'b00000); end
        total++;
        nextCycle();
        memDren = 1'b1; dhit = 1'b1;
        settle();
        if (bEn !== 5'b11111) begin bad++; $display("FAIL lu2_wait_done_en: got %b want %b", bEn, 5'b11111); end
        total++;
        nextCycle();
        settle();
        if (bEn !== 5'b00111) begin bad++; $display("FAIL lu2_resume_bub_en: got %b want %b", bEn, 5'b00111); end
        total++;
        if (aEn !== 5'b11111) begin bad++; $display("FAIL lu1_resume_en: got %b want %b", aEn, 5'b11111); end
        total++;
        nextCycle();
        settle();
        if (bEn !== 5'b11111) begin bad++; $display("FAIL lu2_resume_done_en: got %b want %b", bEn, 5'b11111); end
        total++;
    endtask

    task automatic test_data_wait();
        pulseReset();
        for (int i = 1; i <= 4; i++) begin
            nextCycle();
            memDren = 1'b1;
            settle();
            if (aEn !== 5'b00000) begin bad++; $display("FAIL dwait_en_%0d: got %b want %b", i, aEn, 5'b00000); end
            total++;
            if (aFl !== 3'b000) begin bad++; $display("FAIL dwait_flush_%0d: got %b want %b", i, aFl, 3'b000); end
            total++;
            if (aTimeout !== (i == 4)) begin bad++; $display("FAIL dwait_timeout_%0d: got %b want %b", i, aTimeout, (i == 4)); end
            total++;
        end
        nextCycle();
        memDren = 1'b1; dhit = 1'b1;
        settle();
        if (aEn !== 5'b11111) begin bad++; $display("FAIL dwait_release_en: got %b want %b", aEn, 5'b11111); end
        total++;
        nextCycle();
        settle();
        if (aTimeout !== 1'b1) begin bad++; $display("FAIL timeout_sticky: got %b want %b", aTimeout, 1'b1); end
        total++;
        pulseReset();
        settle();
        if (aTimeout !== 1'b0) begin bad++; $display("FAIL timeout_cleared: got %b want %b", aTimeout, 1'b0); end
        total++;
        // write wait, then a read that hits immediately
        nextCycle();
        memDwen = 1'b1;
        settle();
        if (aEn !== 5'b00000) begin bad++; $display("FAIL dwen_wait_en: got %b want %b", aEn, 5'b00000); end
        total++;
        nextCycle();
        memDwen = 1'b1; dhit = 1'b1;
        settle();
        if (aEn !== 5'b11111) begin bad++; $display("FAIL dwen_release_en: got %b want %b", aEn, 5'b11111); end
        total++;
        nextCycle();
        memDren = 1'b1; dhit = 1'b1;
        settle();
        if (aEn !== 5'b11111) begin bad++; $display("FAIL dren_hit_en: got %b want %b", aEn, 5'b11111); end
        total++;
    endtask

    task automatic test_branch();
        // branch and load-use together: flush wins, no bubble after
        nextCycle();
        exMemRd = 1'b1; exRt = 5'd8; idRs = 5'd8; branchTaken = 1'b1;
        settle();
        if (aEn !== 5'b11111) begin bad++; $display("FAIL br_lu_en: got %b want %b", aEn, 5'b11111); end
        total++;
        if (aFl !== 3'b111) begin bad++; $display("FAIL br_lu_flush: got %b want %b", aFl, 3'b111); end
        total++;
        nextCycle();
        settle();
        if (bEn !== 5'b11111) begin bad++; $display("FAIL br_lu_after_en_b: got %b want %b", bEn, 5'b11111); end
        total++;
        if (bFl !== 3'b000) begin bad++; $display("FAIL br_lu_after_flush_b: got %b want %b", bFl, 3'b000); end
        total++;
        // flush not gated by a fetch miss
        nextCycle();
        branchTaken = 1'b1; ihit = 1'b0;
        settle();
        if (aEn !== 5'b11111) begin bad++; $display("FAIL br_imiss_en: got %b want %b", aEn, 5'b11111); end
        total++;
        if (aFl !== 3'b111) begin bad++; $display("FAIL br_imiss_flush: got %b want %b", aFl, 3'b111); end
        total++;
        // branch cancels an outstanding second bubble
        nextCycle();
        exMemRd = 1'b1; exRt = 5'd2; idRs = 5'd2;
        nextCycle();
        branchTaken = 1'b1;
        settle();
        if (bFl !== 3'b111) begin bad++; $display("FAIL br_cancel_flush_b: got %b want %b", bFl, 3'b111); end
        total++;
        nextCycle();
        settle();
        if (bEn !== 5'b11111) begin bad++; $display("FAIL br_cancel_after_en_b: got %b want %b", bEn, 5'b11111); end
        total++;
    endtask

    task automatic test_ihit_miss();
        nextCycle();
        ihit = 1'b0;
        settle();
        if (aEn !== 5'b00111) begin bad++; $display("FAIL imiss_en: got %b want %b", aEn, 5'b00111); end
        total++;
        if (aFl !== 3'b010) begin bad++; $display("FAIL imiss_flush: got %b want %b", aFl, 3'b010); end
        total++;
        nextCycle();
        settle();
        if (aEn !== 5'b11111) begin bad++; $display("FAIL imiss_after_en: got %b want %b", aEn, 5'b11111); end
        total++;
    endtask

    task automatic test_halt();
        nextCycle();
        wbHalt = 1'b1;
        settle();
        if (aEn !== 5'b00000) begin bad++; $display("FAIL halt_drain_en: got %b want %b", aEn, 5'b00000); end
        total++;
        if (aHalted !== 1'b0) begin bad++; $display("FAIL halt_drain_flag: got %b want %b", aHalted, 1'b0); end
        total++;
        nextCycle();
        ihit = 1'b0; branchTaken = 1'b1;
        settle();
        if (aHalted !== 1'b1) begin bad++; $display("FAIL halted_flag: got %b want %b", aHalted, 1'b1); end
        total++;
        if (aEn !== 5'b00000) begin bad++; $display("FAIL halted_en: got %b want %b", aEn, 5'b00000); end
        total++;
        if (aFl !== 3'b000) begin bad++; $display("FAIL halted_flush: got %b want %b", aFl, 3'b000); end
        total++;
        nextCycle();
        exMemRd = 1'b1; exRt = 5'd3; idRs = 5'd3; memDren = 1'b1; dhit = 1'b1;
        settle();
        if ({aHalted, aEn} !== 6'b100000) begin bad++; $display("FAIL halted_hold: got %b want %b", {aHalted, aEn}, 6'b100000); end
        total++;
        pulseReset();
        settle();
        if (aHalted !== 1'b0) begin bad++; $display("FAIL halt_cleared: got %b want %b", aHalted, 1'b0); end
        total++;
        if (aEn !== 5'b11111) begin bad++; $display("FAIL halt_cleared_en: got %b want %b", aEn, 5'b11111); end
        total++;
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        pulseReset();
        for (int k = 0; k < 2; k++) begin
            nextCycle();
            exMemRd = 1'b1; exRt = 5'd5; idRs = 5'd5;
            nextCycle();
            nextCycle();
        end
        nextCycle();
        branchTaken = 1'b1;
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            memDren = 1'b1;
        end
        nextCycle();
        memDren = 1'b1; dhit = 1'b1;
        nextCycle();
        settle();
        if (aLduCnt !== 32'd2) begin bad++; $display("FAIL perf_ldu: got %0d want %0d", aLduCnt, 2); end
        total++;
        if (aFlushCnt !== 32'd1) begin bad++; $display("FAIL perf_flush: got %0d want %0d", aFlushCnt, 1); end
        total++;
        if (aStall !== 32'd5) begin bad++; $display("FAIL perf_stall: got %0d want %0d", aStall, 5); end
        total++;
        if (bStall !== 32'd7) begin bad++; $display("FAIL perf_stall_b: got %0d want %0d", bStall, 7); end
        total++;
    endtask
`endif

    initial begin
        applyStimulus();
        RST = 1'b1;
        test_reset();
        test_load_use();
        test_load_use_two();
        test_data_wait();
        test_branch();
        test_ihit_miss();
        test_halt();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("[TB] test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline. It owns the enable and flush strobes of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Detects and sequences four conditions: load-use hazards (the ones forwarding cannot cover), taken branch/jump squashes, instruction/data memory wait states, and halt drain.
- Sits beside the forwarding logic and consumes the same register-index and control bits from the stage latches.

Parameters:
- REG_W, 5, register index width.
- LU_BUBBLES, 1, bubbles inserted per load-use hazard (1..3). Set to 2 for non-forwarding builds.
- DWAIT_MAX, 255, data-memory wait cycles before mem_timeout asserts.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- CLK, in, 1, clock.
- RST, in, 1, synchronous active-high reset.
- id_rs, in, REG_W, rs of the instruction in ID.
- id_rt, in, REG_W, rt of the instruction in ID.
- ex_rt, in, REG_W, destination of the load in EX.
- ex_memRd, in, 1, instruction in EX is a load.
- mem_dren, in, 1, MEM stage requests a data read.
- mem_dwen, in, 1, MEM stage requests a data write.
- dhit, in, 1, data memory completes this cycle.
- ihit, in, 1, instruction memory returns a word this cycle.
- mem_branch_taken, in, 1, branch/jump resolved taken in MEM.
- wb_halt, in, 1, halt instruction is in WB.
- pc_en, out, 1, PC load enable.
- ifid_en, out, 1, IF/ID latch enable.
- idex_en, out, 1, ID/EX latch enable.
- exmem_en, out, 1, EX/MEM latch enable.
- memwb_en, out, 1, MEM/WB latch enable.
- ifid_flush, out, 1, IF/ID clear-to-NOP.
- idex_flush, out, 1, ID/EX clear-to-NOP.
- exmem_flush, out, 1, EX/MEM clear-to-NOP.
- halted, out, 1, sticky pipeline-halted flag.
- mem_timeout, out, 1, sticky data-memory timeout error.

Behaviour:
- Clock and reset: one clock CLK; reset RST is synchronous and active-high.
- State and counters: registered state is RUN, LDUSE, DWAIT, HALTED, plus bub_cnt (2 bits) and dwait_cnt (8 bits, saturating).
- Output timing: outputs are combinational from state and inputs.
- Reset: state=RUN, bub_cnt=0, dwait_cnt=0, halted=0, mem_timeout=0. While RST is high: all *_en=0, all *_flush=0.
- Load-use detect: lu = ex_memRd & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt).
- Data wait: dw = (mem_dren | mem_dwen) & !dhit.
- Per-cycle priority: HALTED > dw > mem_branch_taken > lu/LDUSE > !ihit > normal.
- HALTED state: all enables 0, flushes 0, halted=1. Only RST exits.
- Halt drain, any non-HALTED state: if wb_halt, the next state is HALTED. In the current cycle memwb_en=0 and all other enables 0.
- dw, any state, pipeline freeze:
  - All enables 0, no flushes; state becomes DWAIT.
  - dwait_cnt increments, saturating at 255.
  - When dwait_cnt reaches DWAIT_MAX, mem_timeout=1 (sticky).
- DWAIT with dhit=1:
  - All enables 1 this cycle; dwait_cnt clears; next state is RUN.
  - If bub_cnt!=0, the next state is LDUSE instead, so a pending load-use is preserved.
- mem_branch_taken, not dw:
  - pc_en=1, all latch enables 1.
  - ifid_flush=idex_flush=exmem_flush=1.
  - Any LDUSE in progress is cancelled: bub_cnt=0, next state RUN.
  - Flushes are not gated by ihit.
- lu in RUN, or LDUSE with bub_cnt!=0:
  - pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=memwb_en=1.
  - Entering from RUN loads bub_cnt=LU_BUBBLES-1 and the next state is LDUSE, or stays RUN if LU_BUBBLES=1.
  - In LDUSE, bub_cnt decrements; the state returns to RUN when bub_cnt==0 is reached.
- !ihit, normal case: pc_en=0, ifid_en=0, idex_flush=1. Downstream latches are enabled, so the pipe keeps draining.
- Normal: all enables 1, flushes 0.
- Register 0 never triggers a hazard.
- A simultaneous lu and mem_branch_taken resolves to flush only.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, adds output ports stall_cycles (CNT_W), flush_count (CNT_W) and ldu_count (CNT_W).
  - stall_cycles counts cycles with pc_en=0 excluding HALTED.
  - flush_count counts cycles with mem_branch_taken applied.
  - ldu_count counts hazard detections entered from RUN.
  - All three wrap at 2^CNT_W, reset to 0 and freeze in HALTED.
- When undefined: the ports and logic are absent, and the remaining behaviour is identical.

Test Plan:
- Reset with RST=1 for 2 cycles, ihit=1 -> all *_en=0 during reset, then all *_en=1, flushes 0, halted=0.
- ex_memRd=1, ex_rt=5, id_rs=5, LU_BUBBLES=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1, then normal. With ex_rt=0 -> no stall.
- mem_dren=1, dhit=0 for 4 cycles, then dhit=1 -> 4 cycles all enables 0, then one cycle all enables 1. DWAIT_MAX=3 gives mem_timeout=1 from the 4th wait cycle onward.
- mem_branch_taken=1 in the same cycle as lu -> ifid/idex/exmem_flush=1, pc_en=1, no load-use bubble afterwards.
- wb_halt=1 -> HALTED next cycle: halted=1, all enables 0, unaffected by ihit/branch; RST=1 clears it.
- HAZARD_PERF_EN build: 2 load-use hazards + 1 branch + 3 wait cycles -> ldu_count=2, flush_count=1, stall_cycles=5.
